pipeline_stage_buffer: RTL and testbench
========================================

Name: pipeline_stage_buffer

Overview:
- Parametrised inter-stage pipeline register for the CPU datapath. Generalises the fixed per-field stage latches into one payload-width-agnostic, DEPTH-entry elastic buffer.
- Adds valid/ready handshake, stall, bubble (NOP) injection and full flush.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The hazard unit drives its control state.

Parameters:
- DATA_W, 128, payload width in bits (packed stage fields).
- DEPTH, 2, number of entries; legal range 1..16. DEPTH=1 is a plain latch; DEPTH>=2 sustains one transfer per cycle.
- NOP_VALUE, '0, payload written for injected bubbles and driven on out_data when empty.
- CNT_W, $clog2(DEPTH+1), occupancy width (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- stage_ctrl  in  2  pipe_state_t: PIPE_ENABLE, PIPE_STALL, PIPE_NOP, PIPE_FLUSH.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  buffer accepts in_data this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry presented.
- out_ready  in  1  downstream consumes head.
- out_data  out  DATA_W  head payload.
- out_bubble  out  1  head entry is an injected NOP.
- occupancy  out  CNT_W  entries held.

Behaviour:
- Reset is one synchronous cycle with RST=1. It sets head=0, tail=0, count=0 and clears all bubble flags. Storage contents are don't-care.
- Reset values of outputs: out_valid=0, in_ready=0 during the reset cycle, out_data=NOP_VALUE, out_bubble=0, occupancy=0.
- RST mid-transfer discards everything. No push or pop occurs in that cycle.
- Storage: circular register array with head/tail pointers that wrap DEPTH-1 -> 0. DEPTH need not be a power of two. count tracks occupancy.
- Output path: out_data = mem[head] when count>0, else NOP_VALUE. No combinational path from in_data to out_data.
- Latency: an entry written at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Control modes (combinational on stage_ctrl):
  - PIPE_ENABLE:
    - in_ready = (count<DEPTH). No pop-through: when full, in_ready=0 even if out_ready=1.
    - out_valid = (count>0).
    - push = in_valid & in_ready; pop = out_valid & out_ready.
    - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - PIPE_STALL:
    - in_ready=0, out_valid=0.
    - Pointers, count and contents are held, regardless of in_valid/out_ready.
  - PIPE_NOP:
    - in_ready=0; the upstream payload is not consumed.
    - If count<DEPTH, enqueue NOP_VALUE with bubble flag=1.
    - Pop proceeds as in ENABLE.
    - If full, nothing is enqueued and pop still allowed.
  - PIPE_FLUSH:
    - in_ready=0, out_valid=0.
    - At the next edge: count=0, head=tail=0, bubble flags cleared.
    - Flush overrides any pending push/pop.
- out_bubble = bubble flag of the head entry, qualified by count>0.
- Bubbles are ordinary entries for handshake purposes: downstream must pop them.
- occupancy = count, registered.
- stage_ctrl values outside the enum decode as PIPE_STALL.
- Underflow/overflow are impossible by construction. An SVA in the bench checks count<=DEPTH and no pop when empty.

Decomposition:
- cpu_types_pkg gains:
  - typedef enum logic [1:0] pipe_state_t {PIPE_ENABLE=2'b00, PIPE_STALL=2'b01, PIPE_NOP=2'b10, PIPE_FLUSH=2'b11}. This extends the existing PIPE_ENABLE/PIPE_NOP pair; existing encodings stay unchanged.
  - localparam PIPE_BUF_MAX_DEPTH=16.
- One sub-module, pipe_buf_ptr: a parametrised wrap-around pointer with inc/clr inputs, instantiated for head and tail.
- The register array and control decode stay in pipeline_stage_buffer.

Test Plan:
1. Reset/latency (DEPTH=2, DATA_W=32): RST for 1 cycle, then ENABLE with in_valid=1, in_data=0xDEADBEEF, out_ready=0.
   -> occupancy 0 -> 1 after the edge; next cycle out_valid=1, out_data=0xDEADBEEF, out_bubble=0.
2. Full/backpressure (DEPTH=2): push 0x1, 0x2 with out_ready=0.
   -> in_ready=0 at occupancy=2; 0x3 held upstream. Raise out_ready: outputs 0x1, 0x2, 0x3 in order, one per cycle, after in_ready reasserts.
3. Streaming wrap (DEPTH=3): 10 back-to-back pushes 0..9 with out_ready=1 continuously.
   -> outputs 0..9 in order, no gaps after the first, pointers wrap three times, occupancy never >1.
4. NOP injection: occupancy=1 (0xA), PIPE_NOP for 1 cycle with in_valid=1, in_data=0xB, out_ready=0.
   -> in_ready=0; occupancy=2. Pop order is 0xA (out_bubble=0) then NOP_VALUE (out_bubble=1). 0xB is accepted only after returning to ENABLE.
5. Stall hold: occupancy=2, PIPE_STALL for 5 cycles with out_ready=1 and in_valid=1.
   -> out_valid=0, in_ready=0, occupancy stays 2. Back to ENABLE: original head presented unchanged.
6. Flush priority and reset mid-op: occupancy=2, PIPE_FLUSH with in_valid=1, out_ready=1.
   -> no transfer; occupancy=0 next cycle, out_data=NOP_VALUE. Separately, RST asserted with occupancy=2 during push+pop -> occupancy=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: pipeline-control states and buffer limits.
package cpu_types_pkg;

  // Hazard-unit command for a stage buffer. The ENABLE/NOP encodings predate
  // STALL/FLUSH and must not move.
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'b00,
    PIPE_STALL  = 2'b01,
    PIPE_NOP    = 2'b10,
    PIPE_FLUSH  = 2'b11
  } pipe_state_t;

  localparam int PIPE_BUF_MAX_DEPTH = 16;

  // Pointer width able to address depth entries (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Wrap-around index for a circular buffer of DEPTH entries.
// DEPTH need not be a power of two.
module pipe_buf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Pointer register: clear wins over increment, increment wraps after LAST.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (RST || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Elastic inter-stage pipeline register with valid/ready handshake, stall,
// bubble injection and flush. Output is always driven from storage, never
// from in_data, so an entry appears one cycle after it is written.
module pipeline_stage_buffer
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  pipe_state_t       stage_ctrl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  bubble_q;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              not_full;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              flush;
  logic              wr_bubble;
  logic [DATA_W-1:0] wr_data;

  assign not_full  = (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);

  // Decode the hazard-unit command into handshake and storage controls.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    in_ready  = 1'b0;
    out_valid = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    wr_bubble = 1'b0;
    if (!RST) begin
      case (stage_ctrl)
        PIPE_ENABLE: begin
          in_ready  = not_full;
          out_valid = not_empty;
          push      = in_valid && not_full;
        end
        PIPE_NOP: begin
          out_valid = not_empty;
          push      = not_full;
          wr_bubble = 1'b1;
        end
        PIPE_FLUSH: begin
          flush = 1'b1;
        end
        default: begin
          // PIPE_STALL and anything undecodable hold all state.
        end
      endcase
    end
  end

  assign pop     = out_valid && out_ready;
  assign wr_data = wr_bubble ? NOP_VALUE : in_data;

  pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_ptr (
    .CLK (CLK),
    .RST (RST),
    .clr (flush),
    .inc (pop),
    .ptr (head)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_ptr (
    .CLK (CLK),
    .RST (RST),
    .clr (flush),
    .inc (push),
    .ptr (tail)
  );

  // Occupancy counter; simultaneous push and pop leave it unchanged.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  // Payload storage, written at the tail.
  always_ff @(posedge CLK) begin
    // NOTE: payload RAM is deliberately not reset; count gates every read of it.
    if (push) begin
      mem[tail] <= wr_data;
    end
  end

  // Bubble flags: cleared wholesale on reset/flush, tagged per entry on push.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      bubble_q <= '0;
    end else if (push) begin
      bubble_q[tail] <= wr_bubble;
    end
  end

  assign out_data   = not_empty ? mem[head] : NOP_VALUE;
  assign out_bubble = not_empty && bubble_q[head];
  assign occupancy  = count;

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Bench for pipeline_stage_buffer: directed vector table on a DEPTH=2
// instance, streaming wrap and randomized queue-model run on a DEPTH=3 one.
module tb_pipeline_stage_buffer;
  import cpu_types_pkg::*;

  localparam logic [31:0] NOP2 = 32'hB0B0_B0B0;
  localparam logic [31:0] NOP3 = 32'h0000_0000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DEPTH=2 instance signals
  logic        rst2;
  pipe_state_t ctrl2;
  logic        iv2, ir2, ordy2, ov2, ob2;
  logic [31:0] din2, od2;
  logic [1:0]  occ2;

  // DEPTH=3 instance signals
  logic        rst3;
  pipe_state_t ctrl3;
  logic        iv3, ir3, ordy3, ov3, ob3;
  logic [31:0] din3, od3;
  logic [1:0]  occ3;

  pipeline_stage_buffer #(.DATA_W(32), .DEPTH(2), .NOP_VALUE(NOP2)) u_d2 (
    .CLK        (CLK),
    .RST        (rst2),
    .stage_ctrl (ctrl2),
    .in_valid   (iv2),
    .in_ready   (ir2),
    .in_data    (din2),
    .out_valid  (ov2),
    .out_ready  (ordy2),
    .out_data   (od2),
    .out_bubble (ob2),
    .occupancy  (occ2)
  );

  pipeline_stage_buffer #(.DATA_W(32), .DEPTH(3), .NOP_VALUE(NOP3)) u_d3 (
    .CLK        (CLK),
    .RST        (rst3),
    .stage_ctrl (ctrl3),
    .in_valid   (iv3),
    .in_ready   (ir3),
    .in_data    (din3),
    .out_valid  (ov3),
    .out_ready  (ordy3),
    .out_data   (od3),
    .out_bubble (ob3),
    .occupancy  (occ3)
  );

  // Structural safety: occupancy bounded and never a pop from an empty buffer.
  a_d2_bound: assert property (@(posedge CLK) disable iff (rst2) occ2 <= 2'd2)
    else $error("FAIL d2 occupancy bound: %0d", occ2);
  a_d2_nopop: assert property (@(posedge CLK) disable iff (rst2) !(ov2 && ordy2 && occ2 == 2'd0))
    else $error("FAIL d2 pop when empty");
  a_d3_bound: assert property (@(posedge CLK) disable iff (rst3) occ3 <= 2'd3)
    else $error("FAIL d3 occupancy bound: %0d", occ3);
  a_d3_nopop: assert property (@(posedge CLK) disable iff (rst3) !(ov3 && ordy3 && occ3 == 2'd0))
    else $error("FAIL d3 pop when empty");

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        rst;
    pipe_state_t ctrl;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [31:0] dout;
    logic        bub;
    logic [1:0]  occ;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic rst, input pipe_state_t ctrl, input logic iv,
                               input logic [31:0] din, input logic ordy, input logic ir,
                               input logic ov, input logic [31:0] dout, input logic bub,
                               input logic [1:0] occ);
    vec_t v;
    v.rst = rst; v.ctrl = ctrl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.dout = dout; v.bub = bub; v.occ = occ;
    vecs.push_back(v);
  endfunction

  typedef struct {
    logic [31:0] data;
    bit          bub;
  } entry_t;

  entry_t model_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Expected outputs are those seen with the row's inputs applied, before its edge.
    //     rst  ctrl         iv din           ordy ir ov dout          bub occ
    // Reset state, then single push and 1-cycle latency
    addv(0, PIPE_ENABLE, 1, 32'hDEADBEEF, 0,   1, 0, NOP2,         0, 0);
    addv(0, PIPE_ENABLE, 0, 32'h0,        0,   1, 1, 32'hDEADBEEF, 0, 1);
    addv(0, PIPE_ENABLE, 0, 32'h0,        1,   1, 1, 32'hDEADBEEF, 0, 1);
    // Fill to full, backpressure, no pop-through, in-order drain
    addv(0, PIPE_ENABLE, 1, 32'h1,        0,   1, 0, NOP2,         0, 0);
    addv(0, PIPE_ENABLE, 1, 32'h2,        0,   1, 1, 32'h1,        0, 1);
    addv(0, PIPE_ENABLE, 1, 32'h3,        0,   0, 1, 32'h1,        0, 2);
    addv(0, PIPE_ENABLE, 1, 32'h3,        1,   0, 1, 32'h1,        0, 2);
    addv(0, PIPE_ENABLE, 1, 32'h3,        1,   1, 1, 32'h2,        0, 1);
    addv(0, PIPE_ENABLE, 0, 32'h0,        1,   1, 1, 32'h3,        0, 1);
    addv(0, PIPE_ENABLE, 0, 32'h0,        0,   1, 0, NOP2,         0, 0);
    // NOP injection behind 0xA; 0xB held until ENABLE and room
    addv(0, PIPE_ENABLE, 1, 32'hA,        0,   1, 0, NOP2,         0, 0);
    addv(0, PIPE_NOP,    1, 32'hB,        0,   0, 1, 32'hA,        0, 1);
    addv(0, PIPE_ENABLE, 1, 32'hB,        0,   0, 1, 32'hA,        0, 2);
    addv(0, PIPE_ENABLE, 1, 32'hB,        1,   0, 1, 32'hA,        0, 2);
    addv(0, PIPE_ENABLE, 1, 32'hB,        1,   1, 1, NOP2,         1, 1);
    addv(0, PIPE_ENABLE, 0, 32'h0,        0,   1, 1, 32'hB,        0, 1);
    // Stall hold for 5 cycles at occupancy 2
    addv(0, PIPE_ENABLE, 1, 32'hC,        0,   1, 1, 32'hB,        0, 1);
    for (int k = 0; k < 5; k++)
      addv(0, PIPE_STALL, 1, 32'hD,       1,   0, 0, 32'hB,        0, 2);
    addv(0, PIPE_ENABLE, 1, 32'hD,        0,   0, 1, 32'hB,        0, 2);
    // Flush overrides push and pop
    addv(0, PIPE_FLUSH,  1, 32'hD,        1,   0, 0, 32'hB,        0, 2);
    addv(0, PIPE_ENABLE, 0, 32'h0,        0,   1, 0, NOP2,         0, 0);
    // NOP while full: nothing enqueued, pop still happens
    addv(0, PIPE_ENABLE, 1, 32'hE,        0,   1, 0, NOP2,         0, 0);
    addv(0, PIPE_ENABLE, 1, 32'hF,        0,   1, 1, 32'hE,        0, 1);
    addv(0, PIPE_NOP,    0, 32'h0,        1,   0, 1, 32'hE,        0, 2);
    addv(0, PIPE_ENABLE, 0, 32'h0,        0,   1, 1, 32'hF,        0, 1);
    // Reset during push+pop with occupancy 2
    addv(0, PIPE_ENABLE, 1, 32'h10,       0,   1, 1, 32'hF,        0, 1);
    addv(1, PIPE_ENABLE, 1, 32'h11,       1,   0, 0, 32'hF,        0, 2);
    addv(0, PIPE_ENABLE, 0, 32'h0,        0,   1, 0, NOP2,         0, 0);

    // Power-on reset cycle for both instances
    rst2 = 1'b1; ctrl2 = PIPE_ENABLE; iv2 = 1'b0; din2 = '0; ordy2 = 1'b0;
    rst3 = 1'b1; ctrl3 = PIPE_ENABLE; iv3 = 1'b0; din3 = '0; ordy3 = 1'b0;
    tick();
    rst2 = 1'b0;
    rst3 = 1'b0;

    // Directed table on DEPTH=2
    foreach (vecs[i]) begin
      rst2 = vecs[i].rst; ctrl2 = vecs[i].ctrl; iv2 = vecs[i].iv;
      din2 = vecs[i].din; ordy2 = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i),   32'(ir2),  32'(vecs[i].ir));
      check($sformatf("v%0d out_valid", i),  32'(ov2),  32'(vecs[i].ov));
      check($sformatf("v%0d out_data", i),   od2,       vecs[i].dout);
      check($sformatf("v%0d out_bubble", i), 32'(ob2),  32'(vecs[i].bub));
      check($sformatf("v%0d occupancy", i),  32'(occ2), 32'(vecs[i].occ));
      tick();
    end
    rst2 = 1'b0; iv2 = 1'b0; ordy2 = 1'b0;

    // Streaming through DEPTH=3: 10 back-to-back pushes with out_ready held
    for (int k = 0; k <= 10; k++) begin
      ctrl3 = PIPE_ENABLE; iv3 = (k < 10); din3 = 32'(k); ordy3 = 1'b1;
      #1;
      check($sformatf("stream%0d in_ready", k), 32'(ir3), 32'd1);
      check($sformatf("stream%0d occ<=1", k), 32'(occ3 <= 2'd1), 32'd1);
      if (k == 0) begin
        check("stream0 out_valid", 32'(ov3), 32'd0);
      end else begin
        check($sformatf("stream%0d out_valid", k), 32'(ov3), 32'd1);
        check($sformatf("stream%0d out_data", k), od3, 32'(k - 1));
      end
      tick();
    end
    iv3 = 1'b0; ordy3 = 1'b0;
    #1;
    check("stream end out_valid", 32'(ov3), 32'd0);
    check("stream end occupancy", 32'(occ3), 32'd0);
    tick();

    // Randomized run on DEPTH=3 against a queue model
    for (int c = 0; c < 400; c++) begin
      int          r;
      int          sz;
      logic        e_ir, e_ov, e_push, e_pop;
      logic [31:0] e_od;
      logic        e_bub;
      entry_t      e;

      rst3  = ($urandom_range(0, 49) == 0);
      r     = $urandom_range(0, 9);
      ctrl3 = (r < 6) ? PIPE_ENABLE : (r < 8) ? PIPE_STALL : (r == 8) ? PIPE_NOP : PIPE_FLUSH;
      iv3   = $urandom_range(0, 3) != 0;
      ordy3 = $urandom_range(0, 2) != 0;
      din3  = $urandom;
      #1;

      sz     = model_q.size();
      e_ir   = 1'b0;
      e_ov   = 1'b0;
      e_push = 1'b0;
      if (!rst3) begin
        if (ctrl3 == PIPE_ENABLE) begin
          e_ir   = (sz < 3);
          e_ov   = (sz > 0);
          e_push = iv3 && (sz < 3);
        end else if (ctrl3 == PIPE_NOP) begin
          e_ov   = (sz > 0);
          e_push = (sz < 3);
        end
      end
      e_od  = (sz > 0) ? model_q[0].data : NOP3;
      e_bub = (sz > 0) ? model_q[0].bub : 1'b0;

      check($sformatf("rnd%0d in_ready", c),   32'(ir3),  32'(e_ir));
      check($sformatf("rnd%0d out_valid", c),  32'(ov3),  32'(e_ov));
      check($sformatf("rnd%0d out_data", c),   od3,       e_od);
      check($sformatf("rnd%0d out_bubble", c), 32'(ob3),  32'(e_bub));
      check($sformatf("rnd%0d occupancy", c),  32'(occ3), 32'(sz));

      e_pop = e_ov && ordy3;
      if (rst3 || (ctrl3 == PIPE_FLUSH)) begin
        model_q.delete();
      end else begin
        if (e_pop) void'(model_q.pop_front());
        if (e_push) begin
          e.bub  = (ctrl3 == PIPE_NOP);
          e.data = e.bub ? NOP3 : din3;
          model_q.push_back(e);
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
